rm_lane_scheduler: RTL

RM_LANE_SCHEDULER -- requirements
Module: rm_lane_scheduler

---
 rtl/ariane_pkg.sv | 12 +
 rtl/rm_rr_arbiter.sv | 43 ++++
 rtl/rm_lane_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core definitions used by the runtime-monitor lane scheduler.
package ariane_pkg;

    localparam int unsigned RM_NUM_LANES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } rm_lane_state_t;

endpackage

// File: rtl/rm_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
module rm_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               adv_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_next_ptr;

    always_comb begin
        int unsigned idx;
        logic        found;
        gnt_o      = '0;
        w_next_ptr = r_ptr;
        found      = 1'b0;
        idx        = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(r_ptr) + i) % NUM_REQ;
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                w_next_ptr = PTR_W'((idx + 1) % NUM_REQ);
            end
        end
    end

    // Pointer moves only when the grant is actually consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (adv_i) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/rm_lane_scheduler.sv
// Allocates runtime-monitor lanes to requesters; per-lane IDLE/BUSY/DRAIN FSM.
// Optional per-lane watchdog enabled by defining RM_LANE_TIMEOUT_EN.
module rm_lane_scheduler
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_LANES = RM_NUM_LANES,
    parameter int unsigned NUM_REQ   = 2,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [NUM_LANES-1:0] grant_lane_o,
    input  logic [NUM_LANES-1:0] release_i,
    output logic [NUM_LANES-1:0] lane_busy_o,
    output logic [NUM_LANES-1:0] lane_reset_o,
    output logic [NUM_LANES-1:0] timeout_o
);

    rm_lane_state_t       r_state [NUM_LANES];
    logic [NUM_LANES-1:0] r_timeout;

    logic [NUM_LANES-1:0] w_idle;
    logic [NUM_LANES-1:0] w_lane_pick;
    logic [NUM_LANES-1:0] w_to;
    logic [NUM_REQ-1:0]   w_arb_gnt;
    logic                 w_grant_ok;
    logic                 w_xfer;

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_idle[l]       = (r_state[l] == IDLE);
            lane_busy_o[l]  = (r_state[l] != IDLE);
            lane_reset_o[l] = (r_state[l] == DRAIN);
        end
    end

    // rst_ni gating keeps handshakes quiet while the lanes are held in reset.
    assign w_grant_ok   = rst_ni & (|w_idle) & ~flush_i;
    assign req_ready_o  = w_grant_ok ? w_arb_gnt : '0;
    assign w_xfer       = w_grant_ok & (|w_arb_gnt);
    assign w_lane_pick  = w_idle & (~w_idle + NUM_LANES'(1));
    assign grant_lane_o = w_xfer ? w_lane_pick : '0;
    assign timeout_o    = r_timeout;

    rm_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .req_i  (req_valid_i),
        .adv_i  (w_xfer),
        .gnt_o  (w_arb_gnt)
    );

`ifdef RM_LANE_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] r_cnt [NUM_LANES];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_cnt[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (grant_lane_o[l]) begin
                    r_cnt[l] <= '0;
                end else if (r_state[l] == BUSY) begin
                    r_cnt[l] <= r_cnt[l] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            w_to[l] = (r_state[l] == BUSY) && (r_cnt[l] == CNT_W'(TIMEOUT - 1));
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT == 0);
    assign w_to             = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_state[l]   <= IDLE;
                r_timeout[l] <= 1'b0;
            end
        end else begin
            for (int l = 0; l < NUM_LANES; l++) begin
                r_timeout[l] <= 1'b0;
                unique case (r_state[l])
                    IDLE: begin
                        if (grant_lane_o[l]) begin
                            r_state[l] <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (release_i[l] || flush_i || w_to[l]) begin
                            r_state[l]   <= DRAIN;
                            // Watchdog is credited only when nothing else ended the lane.
                            r_timeout[l] <= w_to[l] & ~release_i[l] & ~flush_i;
                        end
                    end
                    DRAIN: begin
                        r_state[l] <= IDLE;
                    end
                    default: begin
                        r_state[l] <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
